// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexes four 5-bit symbol codes onto a 4-digit
// common-anode 7-segment display. It produces active-low seg/an/dp drives,
// latches the symbol word once per frame, and blanks every slot start.
module seg7_scan_driver #(
    parameter int SCAN_DIV  = 100_000,
    parameter int GUARD     = 4,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] seg_data,
    input  logic [3:0]  blink_mask,
    input  logic [3:0]  dp_mask,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp
);
    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCAN_W-1:0]  GUARD_CNT  = SCAN_W'(GUARD);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    // All four codes at 0x0F decode to blank.
    localparam logic [19:0] SHADOW_BLANK = 20'h7BDEF;

    logic [SCAN_W-1:0]  scan_cnt;
    logic [1:0]         digit_idx;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic [3:0][4:0]    shadow;
    logic               fresh;

    logic               scan_wrap;
    logic               blink_wrap;
    logic               frame_load;
    logic               in_guard;
    logic [4:0]         sym;
    logic [6:0]         seg_d;
    logic [3:0]         an_d;
    logic               dp_d;

    // Active-high {g,f,e,d,c,b,a} pattern for each symbol code.
    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        case (code)
            5'h00:   seg_decode = 7'h3F;
            5'h01:   seg_decode = 7'h06;
            5'h02:   seg_decode = 7'h5B;
            5'h03:   seg_decode = 7'h4F;
            5'h04:   seg_decode = 7'h66;
            5'h05:   seg_decode = 7'h6D;
            5'h06:   seg_decode = 7'h7D;
            5'h07:   seg_decode = 7'h07;
            5'h08:   seg_decode = 7'h7F;
            5'h09:   seg_decode = 7'h6F;
            5'h0A:   seg_decode = 7'h54; // n
            5'h0B:   seg_decode = 7'h50; // r
            5'h0C:   seg_decode = 7'h5E; // d
            5'h0D:   seg_decode = 7'h3E; // U
            5'h0E:   seg_decode = 7'h73; // P
            5'h10:   seg_decode = 7'h77; // A
            5'h11:   seg_decode = 7'h7C; // b
            5'h12:   seg_decode = 7'h39; // C
            5'h13:   seg_decode = 7'h79; // E
            5'h14:   seg_decode = 7'h71; // F
            5'h15:   seg_decode = 7'h76; // H
            5'h16:   seg_decode = 7'h38; // L
            5'h17:   seg_decode = 7'h5C; // o
            5'h18:   seg_decode = 7'h78; // t
            5'h19:   seg_decode = 7'h6E; // y
            5'h1A:   seg_decode = 7'h40; // -
            default: seg_decode = 7'h00; // 0x0F and 0x1B-0x1F are blank
        endcase
    endfunction

    assign scan_wrap  = (scan_cnt == SCAN_LAST);
    assign blink_wrap = (blink_cnt == BLINK_LAST);
    // The first edge out of reset counts as a frame start, so the word is
    // captured there as well as on every digit-3 -> digit-0 wrap.
    assign frame_load = fresh || (scan_wrap && (digit_idx == 2'd3));
    assign in_guard   = (scan_cnt < GUARD_CNT);

    // Slot counter and digit index; digit advances on the slot wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_wrap) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            scan_cnt  <= scan_cnt + SCAN_W'(1);
        end
    end

    // Free-running blink timebase, independent of slot alignment.
    always_ff @(posedge clk) begin
        if (!reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_wrap) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + BLINK_W'(1);
        end
    end

    // Frame latch: the display only ever shows a whole, consistent word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow <= SHADOW_BLANK;
            fresh  <= 1'b1;
        end else begin
            fresh <= 1'b0;
            if (frame_load) shadow <= seg_data;
        end
    end

    // Next output drive: dark in the guard, else one anode plus decoded digit.
    always_comb begin
        sym  = shadow[digit_idx];
        an_d = 4'hF;
        seg_d = 7'h7F;
        dp_d = 1'b1;
        if (!in_guard) begin
            an_d = ~(4'b0001 << digit_idx);
            if (!(blink_phase && blink_mask[digit_idx])) begin
                seg_d = ~seg_decode(sym);
                dp_d  = ~dp_mask[digit_idx];
            end
        end
    end

    // Output register; reset forces everything dark on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            seg <= 7'h7F;
            an  <= 4'hF;
            dp  <= 1'b1;
        end else begin
            seg <= seg_d;
            an  <= an_d;
            dp  <= dp_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a frame-level reference pushes the expected
// output for each edge, and each test pops and compares after the edge.
module tb_seg7_scan_driver;
    localparam int SD = 8;
    localparam int GD = 2;
    localparam int BD = 64;
    localparam int FR = 4 * SD;

    localparam logic [6:0] SEG_TBL [32] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h54, 7'h50, 7'h5E, 7'h3E, 7'h73, 7'h00,
        7'h77, 7'h7C, 7'h39, 7'h79, 7'h71, 7'h76, 7'h38, 7'h5C,
        7'h78, 7'h6E, 7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] seg_data;
    logic [3:0]  blink_mask;
    logic [3:0]  dp_mask;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;

    exp_t        exp_q[$];
    logic [19:0] frame_word;
    int          n;
    int          checks = 0;
    int          errors = 0;

    seg7_scan_driver #(.SCAN_DIV(SD), .GUARD(GD), .BLINK_DIV(BD)) dut (
        .clk        (clk),
        .reset      (reset),
        .seg_data   (seg_data),
        .blink_mask (blink_mask),
        .dp_mask    (dp_mask),
        .seg        (seg),
        .an         (an),
        .dp         (dp)
    );

    always #5 clk = ~clk;

    // At most one anode may ever be driven low.
    always @(negedge clk) begin
        checks++;
        assert ($countones(~an) <= 1)
        else begin
            errors++;
            $display("FAIL anode_exclusive t=%0t: an=%b, expected at most one low bit", $time, an);
        end
    end

    // Reference for output n (n = edges since reset release): slot from n,
    // blink phase from n, symbol word from the frame it belongs to.
    task automatic push_expected();
        exp_t       e;
        int         slot;
        int         pos;
        logic [4:0] code;
        logic       blank;
        if (n == 0) frame_word = seg_data;
        slot = (n / SD) % 4;
        pos  = n % SD;
        e    = '{4'hF, 7'h7F, 1'b1};
        if (pos >= GD) begin
            e.an[slot] = 1'b0;
            code  = frame_word[slot*5 +: 5];
            blank = (((n / BD) % 2) == 1) && blink_mask[slot];
            if (!blank) begin
                e.seg = ~SEG_TBL[code];
                e.dp  = ~dp_mask[slot];
            end
        end
        exp_q.push_back(e);
        if ((n % FR) == FR - 1) frame_word = seg_data;
        n++;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        seg_data   = 20'h7BC21;
        blink_mask = 4'h0;
        dp_mask    = 4'h0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d: got an=%h seg=%h dp=%b, expected an=f seg=7f dp=1", i, an, seg, dp);
            end
        end
    endtask

    task automatic test_first_frame();
        exp_t e;
        int   s0_hits = 0;
        reset = 1'b1;
        n     = 0;
        for (int i = 0; i < FR; i++) begin
            push_expected();
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({an, seg, dp} !== e) begin
                errors++;
                $display("FAIL first_frame n=%0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b", n-1, an, seg, dp, e.an, e.seg, e.dp);
            end
            if (an == 4'hE && seg == 7'h79) s0_hits++;
        end
        checks++;
        if (s0_hits != SD - GD) begin
            errors++;
            $display("FAIL first_frame_slot0 got %0d lit cycles, expected %0d", s0_hits, SD - GD);
        end
    endtask

    task automatic test_frame_latch();
        exp_t e;
        int   old_hits = 0;
        int   zero_hits = 0;
        while (n < 3 * FR) begin
            if (n == FR + SD + 4) seg_data = 20'h00000; // mid slot 1
            push_expected();
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({an, seg, dp} !== e) begin
                errors++;
                $display("FAIL frame_latch n=%0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b", n-1, an, seg, dp, e.an, e.seg, e.dp);
            end
            if (n - 1 < 2 * FR && seg == 7'h79) old_hits++;
            if (n - 1 >= 2 * FR && seg == 7'h40) zero_hits++;
        end
        checks++;
        if (old_hits != 2 * (SD - GD)) begin
            errors++;
            $display("FAIL frame_latch_hold got %0d, expected %0d", old_hits, 2 * (SD - GD));
        end
        checks++;
        if (zero_hits != 4 * (SD - GD)) begin
            errors++;
            $display("FAIL frame_latch_next got %0d, expected %0d", zero_hits, 4 * (SD - GD));
        end
    endtask

    // New code is driven on the cycle of the latch edge itself, so it must
    // be captured immediately and shown in the very next frame.
    task automatic test_decode_sweep();
        exp_t e;
        for (int c = 0; c <= 32; c++) begin
            for (int i = 0; i < FR; i++) begin
                if (i == FR - 1) seg_data = {15'h3DEF, 5'(c)};
                push_expected();
                @(posedge clk); #1;
                e = exp_q.pop_front();
                checks++;
                if ({an, seg, dp} !== e) begin
                    errors++;
                    $display("FAIL decode_sweep n=%0d code=%0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b", n-1, c-1, an, seg, dp, e.an, e.seg, e.dp);
                end
            end
        end
    endtask

    task automatic test_blink_dp();
        exp_t e;
        int   dp_low = 0;
        int   d0_an = 0;
        int   d0_lit = 0;
        blink_mask = 4'b0001;
        dp_mask    = 4'b0010;
        seg_data   = 20'h00000;
        for (int i = 0; i < 8 * FR; i++) begin
            push_expected();
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({an, seg, dp} !== e) begin
                errors++;
                $display("FAIL blink_dp n=%0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b", n-1, an, seg, dp, e.an, e.seg, e.dp);
            end
            if (dp == 1'b0) dp_low++;
            if (an == 4'hE) d0_an++;
            if (an == 4'hE && seg != 7'h7F) d0_lit++;
        end
        checks++;
        if (dp_low != 8 * (SD - GD)) begin
            errors++;
            $display("FAIL blink_dp_count got %0d, expected %0d", dp_low, 8 * (SD - GD));
        end
        checks++;
        if (d0_an != 8 * (SD - GD)) begin
            errors++;
            $display("FAIL blink_anode_cycles got %0d, expected %0d", d0_an, 8 * (SD - GD));
        end
        checks++;
        if (d0_lit != 4 * (SD - GD)) begin
            errors++;
            $display("FAIL blink_visible got %0d, expected %0d", d0_lit, 4 * (SD - GD));
        end
    endtask

    task automatic test_reset_mid_slot();
        exp_t e;
        while ((n % FR) != 2 * SD + 3) begin
            push_expected();
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({an, seg, dp} !== e) begin
                errors++;
                $display("FAIL pre_reset n=%0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b", n-1, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_slot: got an=%h seg=%h dp=%b, expected an=f seg=7f dp=1", an, seg, dp);
        end
        reset    = 1'b1;
        seg_data = 20'h08421;
        n        = 0;
        for (int i = 0; i < 2 * FR; i++) begin
            push_expected();
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({an, seg, dp} !== e) begin
                errors++;
                $display("FAIL restart n=%0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b", n-1, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    endtask

    task automatic test_random_frames();
        exp_t e;
        int   dark = 0;
        for (int i = 0; i < 10 * FR; i++) begin
            seg_data   = 20'($urandom);
            blink_mask = 4'($urandom);
            dp_mask    = 4'($urandom);
            push_expected();
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({an, seg, dp} !== e) begin
                errors++;
                $display("FAIL random n=%0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b", n-1, an, seg, dp, e.an, e.seg, e.dp);
            end
            if (an == 4'hF) dark++;
            if (((n - 1) % SD) == SD - 1) begin
                checks++;
                if (dark != GD) begin
                    errors++;
                    $display("FAIL guard_per_slot n=%0d: got %0d dark cycles, expected %0d", n-1, dark, GD);
                end
                dark = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_frame_latch();
        test_decode_sweep();
        test_blink_dp();
        test_reset_mid_slot();
        test_random_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Downstream display stage for the game-mode blocks. It takes the 20-bit `seg_data` word (four 5-bit symbol codes) and time-multiplexes it onto a 4-digit common-anode 7-segment display, producing active-low segment, anode and decimal-point drives. It decodes each symbol code, latches `seg_data` once per frame so the display never tears, inserts an anode-off guard interval at every digit switch, and supports per-digit blink and decimal-point masks.

## Interface
- `SCAN_DIV`, 100_000: clock cycles per digit slot (1 kHz slot rate, 250 Hz frame rate at 100 MHz); must be ≥ 2.
- `GUARD`, 4: cycles at the start of each slot with all anodes off; must satisfy 1 ≤ `GUARD` < `SCAN_DIV`.
- `BLINK_DIV`, 25_000_000: cycles per blink phase; the blink period is 2·`BLINK_DIV`.
- `clk`  in  1  system clock; the single clock domain.
- `reset`  in  1  synchronous, active-low reset. Sampled on the `clk` rising edge; 0 = reset.
- `seg_data`  in  20  symbol codes. [19:15] is the leftmost digit (digit 3); [4:0] is the rightmost digit (digit 0).
- `blink_mask`  in  4  bit k=1 makes digit k blink.
- `dp_mask`  in  4  bit k=1 lights the decimal point of digit k.
- `seg`  out  7  active-low segments, {g,f,e,d,c,b,a}, registered.
- `an`  out  4  active-low anodes; bit k drives digit k. Registered.
- `dp`  out  1  active-low decimal point, registered.

## Operation
- **Internal state:**
  - `scan_cnt` counts 0..SCAN_DIV−1 and wraps.
  - `digit_idx` counts 0..3; it advances (3 wraps to 0) on the edge where `scan_cnt` wraps.
  - `blink_cnt` counts 0..BLINK_DIV−1; `blink_phase` toggles when `blink_cnt` wraps.
  - `shadow[19:0]` holds the latched symbol word.
- **Frame latch:** `shadow` ← `seg_data` on the first edge of every frame, i.e. the edge entering `digit_idx`=0, `scan_cnt`=0. This includes the first edge after reset release. Changes to `seg_data` mid-frame are ignored until the next frame.
- **Decode (active-high abcdefg hex; the output is its bitwise inverse):**
  - Digits: 0x00→3F, 0x01→06, 0x02→5B, 0x03→4F, 0x04→66, 0x05→6D, 0x06→7D, 0x07→07, 0x08→7F, 0x09→6F.
  - Letters: 0x0A `n`→54, 0x0B `r`→50, 0x0C `d`→5E, 0x0D `U`→3E, 0x0E `P`→73, 0x0F blank→00.
  - Extended: 0x10 `A`→77, 0x11 `b`→7C, 0x12 `C`→39, 0x13 `E`→79, 0x14 `F`→71, 0x15 `H`→76, 0x16 `L`→38, 0x17 `o`→5C, 0x18 `t`→78, 0x19 `y`→6E, 0x1A `-`→40.
  - 0x1B–0x1F decode to blank.
- **Slot output:** k = `digit_idx`.
  - Guard (`scan_cnt` < `GUARD`): `an`=4'hF, `seg`=7'h7F, `dp`=1.
  - Otherwise: `an` = ~(1<<k); `seg` = ~decode(`shadow`[5k+4:5k]); `dp` = ~`dp_mask`[k].
- **Blink:** when `blink_phase`=1 and `blink_mask`[k]=1, force `seg`=7'h7F and `dp`=1 for digit k. The anode still cycles normally.
- **Mask timing:** `blink_mask` and `dp_mask` are sampled live, not latched with the frame.

## Timing
- **Reset** (`reset`=0 at an edge) applies on that edge:
  - `scan_cnt`=0, `digit_idx`=0, `blink_cnt`=0, `blink_phase`=0.
  - `shadow`=20'h7BDEF (all blank).
  - `seg`=7'h7F, `an`=4'hF, `dp`=1.
  - Reset mid-frame abandons the frame immediately; there is no partial completion.
- **Output register:** outputs are registered and lag the internal counters by one cycle. Because `GUARD` ≥ 1, the first cycle of a slot is always dark, which hides the shadow load and the decode latency.
- **Slot shape:** each slot spans exactly `SCAN_DIV` output cycles: `GUARD` cycles with `an`=4'hF, then `SCAN_DIV`−`GUARD` cycles with one anode low. A frame is 4·`SCAN_DIV` cycles, in digit order 0,1,2,3.
- **Anode exclusivity:** at most one `an` bit is ever low, on any cycle, including across reset.
- **Blink phase:** the first `BLINK_DIV` cycles after reset release are visible (phase 0). The phase then alternates every `BLINK_DIV` cycles, independent of slot alignment.
- **Simultaneous events:** if `seg_data` changes on the same edge as the frame latch, the new value is captured. If it changes one cycle later, it appears in the following frame.

## Test plan
Bench parameters: `SCAN_DIV`=8, `GUARD`=2, `BLINK_DIV`=64.
- **Reset and first frame:** hold `reset`=0 for 3 cycles, then release with `seg_data`=20'h7BC21 (F,F,1,1). Required:
  - `an`=F during reset and guard cycles.
  - Slot 0: `an`=E, `seg`=7'h79 for 6 cycles.
  - Slot 1: `an`=D, `seg`=7'h79.
  - Slots 2 and 3: `seg`=7'h7F (blank).
- **Frame-boundary latch:** change `seg_data` mid-slot 1 to 20'h00000. Required: the current frame is unchanged; the next frame shows `seg`=7'h40 (`0`) on all digits.
- **Full decode sweep:** step the digit-0 code through 0x00–0x1F, one per frame. Each displayed `seg` must equal the inverse of the table value; 0x1B–0x1F give 7'h7F.
- **Blink and dp:** set `blink_mask`=4'b0001 and `dp_mask`=4'b0010. Required:
  - Digit 0 is lit for 64 cycles, blank for 64 cycles, and repeats.
  - `dp`=0 only during digit-1 non-guard cycles.
- **Reset mid-slot:** assert `reset`=0 for 1 cycle during slot 2. Required: `an`=F on the next output cycle, and the scan restarts at digit 0 with a fresh frame latch.
- **Anode exclusivity:** an assertion checks every cycle of a 10-frame random-`seg_data` run that `an` has at most one zero bit, and that exactly `GUARD` cycles of `an`=F occur per slot.
